tlb_op_ctrl: RTL and testbench

- Sequences the TLB-management instructions (tlbp, tlbr, tlbwi) committed in the WB stage against the shared TLB.
- Arbitrates the TLB's single data-side search port between EX-stage memory lookups and tlbp probes.
- Holds WB while an op is in flight, then signals CP0 capture and the refetch restart.
- Sits between wb_stage, the CP0 register block and the TLB array.

---
 rtl/tlb_op_ctrl_pkg.sv | 22 ++
 rtl/tlb_search_mux.sv | 34 +++
 rtl/tlb_op_ctrl.sv | 117 +++++++++++
 tb/tb_tlb_op_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared types and widths for the TLB-management op sequencer.
package tlb_op_ctrl_pkg;

    localparam int unsigned Vpn2Width     = 19;
    localparam int unsigned AsidWidth     = 8;
    localparam int unsigned TlbNumDefault = 16;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPSrch   = 3'd1,
        StPDone   = 3'd2,
        StRRead   = 3'd3,
        StWWrite  = 3'd4,
        StRefetch = 3'd5
    } tlb_op_state_e;

    // States in which the op has not yet reached its retire cycle.
    function automatic logic op_holds_wb(input tlb_op_state_e st);
        return (st == StPSrch) || (st == StRRead) || (st == StWWrite);
    endfunction

endpackage

// File: rtl/tlb_search_mux.sv
// Data-side TLB search port select: tlbp probe owns the port in P_SRCH, EX lookups otherwise.
module tlb_search_mux
    import tlb_op_ctrl_pkg::*;
(
    input  logic                 probe_active,
    input  logic [Vpn2Width-1:0] probe_vpn2,
    input  logic [AsidWidth-1:0] probe_asid,
    input  logic                 es_lookup_req,
    input  logic [Vpn2Width-1:0] es_vpn2,
    input  logic                 es_odd_page,
    input  logic [AsidWidth-1:0] cp0_entryhi_asid,
    output logic [Vpn2Width-1:0] s1_vpn2,
    output logic                 s1_odd_page,
    output logic [AsidWidth-1:0] s1_asid,
    output logic                 es_lookup_grant,
    output logic                 es_tlb_stall
);

    always_comb begin
        s1_vpn2         = es_vpn2;
        s1_odd_page     = es_odd_page;
        s1_asid         = cp0_entryhi_asid;
        es_lookup_grant = es_lookup_req;
        if (probe_active) begin
            // Probe matches on the VPN2 pair, so the odd-page select is irrelevant.
            s1_vpn2         = probe_vpn2;
            s1_odd_page     = 1'b0;
            s1_asid         = probe_asid;
            es_lookup_grant = 1'b0;
        end
        es_tlb_stall = es_lookup_req && !es_lookup_grant;
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences tlbp/tlbr/tlbwi committed in WB against the shared TLB and arbitrates its search port.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int unsigned TLBNUM = TlbNumDefault,
    parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ws_tlbp_req,
    input  logic                 ws_tlbr_req,
    input  logic                 ws_tlbwi_req,
    input  logic                 ws_reflush,
    input  logic [Vpn2Width-1:0] cp0_entryhi_vpn2,
    input  logic [AsidWidth-1:0] cp0_entryhi_asid,
    input  logic [IDXW-1:0]      cp0_index,
    input  logic                 es_lookup_req,
    input  logic [Vpn2Width-1:0] es_vpn2,
    input  logic                 es_odd_page,
    output logic [Vpn2Width-1:0] s1_vpn2,
    output logic                 s1_odd_page,
    output logic [AsidWidth-1:0] s1_asid,
    input  logic                 s1_found,
    input  logic [IDXW-1:0]      s1_index,
    output logic                 tlb_we,
    output logic [IDXW-1:0]      tlb_w_index,
    output logic [IDXW-1:0]      tlb_r_index,
    output logic                 es_lookup_grant,
    output logic                 es_tlb_stall,
    output logic                 ws_op_stall,
    output logic                 tlbp_done,
    output logic                 tlbp_found,
    output logic [IDXW-1:0]      tlbp_index,
    output logic                 tlbr_done,
    output logic                 refetch_req
);

    tlb_op_state_e        state_q;
    logic [Vpn2Width-1:0] probe_vpn2_q;
    logic [AsidWidth-1:0] probe_asid_q;
    logic                 tlbp_found_q;
    logic [IDXW-1:0]      tlbp_index_q;
    logic                 any_req;
    logic                 accept;

    assign any_req = ws_tlbp_req || ws_tlbr_req || ws_tlbwi_req;
    // A request arriving with a flush belongs to a cancelled instruction.
    assign accept  = (state_q == StIdle) && any_req && !ws_reflush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            probe_vpn2_q <= '0;
            probe_asid_q <= '0;
            tlbp_found_q <= 1'b0;
            tlbp_index_q <= '0;
        end else if ((state_q != StIdle) && ws_reflush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (ws_tlbwi_req) begin
                            state_q <= StWWrite;
                        end else if (ws_tlbr_req) begin
                            state_q <= StRRead;
                        end else begin
                            state_q      <= StPSrch;
                            probe_vpn2_q <= cp0_entryhi_vpn2;
                            probe_asid_q <= cp0_entryhi_asid;
                        end
                    end
                end
                StPSrch: begin
                    tlbp_found_q <= s1_found;
                    tlbp_index_q <= s1_index;
                    state_q      <= StPDone;
                end
                StPDone:   state_q <= StIdle;
                StRRead:   state_q <= StRefetch;
                StWWrite:  state_q <= StRefetch;
                StRefetch: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ws_op_stall = !ws_reflush && (accept || op_holds_wb(state_q));
        tlbp_done   = !ws_reflush && (state_q == StPDone);
        tlbr_done   = !ws_reflush && (state_q == StRRead);
        refetch_req = !ws_reflush && (state_q == StRefetch);
        // Once in W_WRITE the write commits even if WB is being flushed.
        tlb_we      = (state_q == StWWrite);
        tlb_w_index = cp0_index;
        tlb_r_index = cp0_index;
    end

    assign tlbp_found = tlbp_found_q;
    assign tlbp_index = tlbp_index_q;

    tlb_search_mux u_search_mux (
        .probe_active     (state_q == StPSrch),
        .probe_vpn2       (probe_vpn2_q),
        .probe_asid       (probe_asid_q),
        .es_lookup_req    (es_lookup_req),
        .es_vpn2          (es_vpn2),
        .es_odd_page      (es_odd_page),
        .cp0_entryhi_asid (cp0_entryhi_asid),
        .s1_vpn2          (s1_vpn2),
        .s1_odd_page      (s1_odd_page),
        .s1_asid          (s1_asid),
        .es_lookup_grant  (es_lookup_grant),
        .es_tlb_stall     (es_tlb_stall)
    );

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: per-scenario tasks with hand-computed expectations.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_tlbp_req, ws_tlbr_req, ws_tlbwi_req, ws_reflush;
    logic [18:0] cp0_entryhi_vpn2;
    logic [7:0]  cp0_entryhi_asid;
    logic [3:0]  cp0_index;
    logic        es_lookup_req;
    logic [18:0] es_vpn2;
    logic        es_odd_page;
    logic [18:0] s1_vpn2;
    logic        s1_odd_page;
    logic [7:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index;
    logic        tlb_we;
    logic [3:0]  tlb_w_index, tlb_r_index;
    logic        es_lookup_grant, es_tlb_stall, ws_op_stall;
    logic        tlbp_done, tlbp_found, tlbr_done, refetch_req;
    logic [3:0]  tlbp_index;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .ws_tlbp_req      (ws_tlbp_req),
        .ws_tlbr_req      (ws_tlbr_req),
        .ws_tlbwi_req     (ws_tlbwi_req),
        .ws_reflush       (ws_reflush),
        .cp0_entryhi_vpn2 (cp0_entryhi_vpn2),
        .cp0_entryhi_asid (cp0_entryhi_asid),
        .cp0_index        (cp0_index),
        .es_lookup_req    (es_lookup_req),
        .es_vpn2          (es_vpn2),
        .es_odd_page      (es_odd_page),
        .s1_vpn2          (s1_vpn2),
        .s1_odd_page      (s1_odd_page),
        .s1_asid          (s1_asid),
        .s1_found         (s1_found),
        .s1_index         (s1_index),
        .tlb_we           (tlb_we),
        .tlb_w_index      (tlb_w_index),
        .tlb_r_index      (tlb_r_index),
        .es_lookup_grant  (es_lookup_grant),
        .es_tlb_stall     (es_tlb_stall),
        .ws_op_stall      (ws_op_stall),
        .tlbp_done        (tlbp_done),
        .tlbp_found       (tlbp_found),
        .tlbp_index       (tlbp_index),
        .tlbr_done        (tlbr_done),
        .refetch_req      (refetch_req)
    );

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (tlbp_done !== 1'b0) begin failures++;
            $display("FAIL reset_tlbp_done got=%0h exp=0", tlbp_done); end
        checks++; if (tlbp_found !== 1'b0) begin failures++;
            $display("FAIL reset_tlbp_found got=%0h exp=0", tlbp_found); end
        checks++; if (tlbp_index !== 4'd0) begin failures++;
            $display("FAIL reset_tlbp_index got=%0h exp=0", tlbp_index); end
        checks++; if (ws_op_stall !== 1'b0) begin failures++;
            $display("FAIL reset_ws_op_stall got=%0h exp=0", ws_op_stall); end
        checks++; if (es_lookup_grant !== 1'b0) begin failures++;
            $display("FAIL reset_grant got=%0h exp=0", es_lookup_grant); end
        checks++; if ({tlb_we, tlbr_done, refetch_req} !== 3'b000) begin failures++;
            $display("FAIL reset_strobes got=%0b exp=000", {tlb_we, tlbr_done, refetch_req}); end
    endtask

    task automatic test_tlbp_hit();
        // Accept cycle: EX still owns the search port.
        next_cycle();
        cp0_entryhi_vpn2 = 19'h12345; cp0_entryhi_asid = 8'h05;
        ws_tlbp_req = 1'b1; es_lookup_req = 1'b1; es_vpn2 = 19'h0abcd; es_odd_page = 1'b1;
        @(negedge clk);
        checks++; if (ws_op_stall !== 1'b1) begin failures++;
            $display("FAIL tlbp_accept_stall got=%0h exp=1", ws_op_stall); end
        checks++; if ({es_lookup_grant, es_tlb_stall} !== 2'b10) begin failures++;
            $display("FAIL tlbp_accept_grant got=%0b exp=10", {es_lookup_grant, es_tlb_stall}); end
        checks++; if (s1_vpn2 !== 19'h0abcd) begin failures++;
            $display("FAIL tlbp_accept_s1_vpn2 got=%0h exp=abcd", s1_vpn2); end
        // P_SRCH: probe uses the EntryHi copy latched at accept, not the live value.
        next_cycle();
        cp0_entryhi_vpn2 = 19'h7ffff; cp0_entryhi_asid = 8'h33;
        s1_found = 1'b1; s1_index = 4'd7;
        @(negedge clk);
        checks++; if (s1_vpn2 !== 19'h12345) begin failures++;
            $display("FAIL tlbp_srch_s1_vpn2 got=%0h exp=12345", s1_vpn2); end
        checks++; if ({s1_asid, s1_odd_page} !== {8'h05, 1'b0}) begin failures++;
            $display("FAIL tlbp_srch_asid_odd got=%0h/%0h exp=5/0", s1_asid, s1_odd_page); end
        checks++; if ({es_lookup_grant, es_tlb_stall} !== 2'b01) begin failures++;
            $display("FAIL tlbp_srch_grant got=%0b exp=01", {es_lookup_grant, es_tlb_stall}); end
        checks++; if ({ws_op_stall, tlbp_done} !== 2'b10) begin failures++;
            $display("FAIL tlbp_srch_stall_done got=%0b exp=10", {ws_op_stall, tlbp_done}); end
        // P_DONE: results come from the register, not the live search port.
        next_cycle();
        s1_found = 1'b0; s1_index = 4'd0;
        @(negedge clk);
        checks++; if ({tlbp_done, tlbp_found, tlbp_index} !== {1'b1, 1'b1, 4'd7}) begin
            failures++;
            $display("FAIL tlbp_done_result got=%0h/%0h/%0h exp=1/1/7",
                     tlbp_done, tlbp_found, tlbp_index); end
        checks++; if ({ws_op_stall, es_tlb_stall, es_lookup_grant} !== 3'b001) begin failures++;
            $display("FAIL tlbp_done_stalls got=%0b exp=001",
                     {ws_op_stall, es_tlb_stall, es_lookup_grant}); end
        next_cycle();
        ws_tlbp_req = 1'b0; es_lookup_req = 1'b0;
        cp0_entryhi_vpn2 = 19'h0; cp0_entryhi_asid = 8'h0;
        @(negedge clk);
        checks++; if (tlbp_done !== 1'b0) begin failures++;
            $display("FAIL tlbp_after_done got=%0h exp=0", tlbp_done); end
    endtask

    task automatic test_tlbwi();
        next_cycle();
        cp0_index = 4'd3; ws_tlbwi_req = 1'b1;
        @(negedge clk);
        checks++; if ({ws_op_stall, tlb_we} !== 2'b10) begin failures++;
            $display("FAIL tlbwi_accept got=%0b exp=10", {ws_op_stall, tlb_we}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({tlb_we, tlb_w_index, ws_op_stall, refetch_req} !== {1'b1, 4'd3, 2'b10})
        begin failures++;
            $display("FAIL tlbwi_write got=we%0h idx%0h st%0h rf%0h exp=we1 idx3 st1 rf0",
                     tlb_we, tlb_w_index, ws_op_stall, refetch_req); end
        next_cycle();
        @(negedge clk);
        checks++; if ({tlb_we, refetch_req, ws_op_stall} !== 3'b010) begin failures++;
            $display("FAIL tlbwi_refetch got=%0b exp=010", {tlb_we, refetch_req, ws_op_stall}); end
        next_cycle();
        ws_tlbwi_req = 1'b0;
        @(negedge clk);
        checks++; if ({tlb_we, refetch_req} !== 2'b00) begin failures++;
            $display("FAIL tlbwi_idle got=%0b exp=00", {tlb_we, refetch_req}); end
    endtask

    task automatic test_tlbr();
        next_cycle();
        cp0_index = 4'd15; ws_tlbr_req = 1'b1;
        @(negedge clk);
        checks++; if ({ws_op_stall, tlbr_done} !== 2'b10) begin failures++;
            $display("FAIL tlbr_accept got=%0b exp=10", {ws_op_stall, tlbr_done}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({tlb_r_index, tlbr_done, ws_op_stall, refetch_req} !== {4'd15, 3'b110})
        begin failures++;
            $display("FAIL tlbr_read got=idx%0h d%0h st%0h rf%0h exp=idxf d1 st1 rf0",
                     tlb_r_index, tlbr_done, ws_op_stall, refetch_req); end
        next_cycle();
        @(negedge clk);
        checks++; if ({tlbr_done, refetch_req, ws_op_stall} !== 3'b010) begin failures++;
            $display("FAIL tlbr_refetch got=%0b exp=010", {tlbr_done, refetch_req, ws_op_stall}); end
        next_cycle();
        ws_tlbr_req = 1'b0;
        @(negedge clk);
        checks++; if (refetch_req !== 1'b0) begin failures++;
            $display("FAIL tlbr_idle got=%0h exp=0", refetch_req); end
    endtask

    task automatic test_tlbp_miss();
        next_cycle();
        cp0_entryhi_vpn2 = 19'h00777; cp0_entryhi_asid = 8'h21; ws_tlbp_req = 1'b1;
        next_cycle();
        s1_found = 1'b0; s1_index = 4'd9;
        @(negedge clk);
        checks++; if ({s1_vpn2, s1_asid} !== {19'h00777, 8'h21}) begin failures++;
            $display("FAIL tlbp_miss_probe got=%0h/%0h exp=777/21", s1_vpn2, s1_asid); end
        next_cycle();
        es_lookup_req = 1'b1; es_vpn2 = 19'h4321a; es_odd_page = 1'b0;
        @(negedge clk);
        checks++; if ({tlbp_done, tlbp_found} !== 2'b10) begin failures++;
            $display("FAIL tlbp_miss_done got=%0b exp=10", {tlbp_done, tlbp_found}); end
        checks++; if ({es_lookup_grant, es_tlb_stall, s1_vpn2} !== {2'b10, 19'h4321a}) begin
            failures++;
            $display("FAIL tlbp_miss_es_grant got=%0h/%0h/%0h exp=1/0/4321a",
                     es_lookup_grant, es_tlb_stall, s1_vpn2); end
        next_cycle();
        ws_tlbp_req = 1'b0; es_lookup_req = 1'b0;
    endtask

    task automatic test_reflush_tlbr();
        next_cycle();
        cp0_index = 4'd6; ws_tlbr_req = 1'b1;
        next_cycle();
        ws_tlbr_req = 1'b0; ws_reflush = 1'b1;
        @(negedge clk);
        checks++; if ({tlbr_done, ws_op_stall, refetch_req} !== 3'b000) begin failures++;
            $display("FAIL reflush_rread got=%0b exp=000", {tlbr_done, ws_op_stall, refetch_req}); end
        next_cycle();
        ws_reflush = 1'b0;
        @(negedge clk);
        checks++; if ({tlbr_done, refetch_req, ws_op_stall} !== 3'b000) begin failures++;
            $display("FAIL reflush_next got=%0b exp=000", {tlbr_done, refetch_req, ws_op_stall}); end
        next_cycle();
        @(negedge clk);
        checks++; if (refetch_req !== 1'b0) begin failures++;
            $display("FAIL reflush_no_refetch got=%0h exp=0", refetch_req); end
    endtask

    task automatic test_simultaneous();
        next_cycle();
        cp0_index = 4'd5; ws_tlbwi_req = 1'b1; ws_tlbp_req = 1'b1;
        cp0_entryhi_vpn2 = 19'h11111; es_vpn2 = 19'h22222;
        next_cycle();
        @(negedge clk);
        checks++; if ({tlb_we, tlb_w_index, tlbp_done} !== {1'b1, 4'd5, 1'b0}) begin failures++;
            $display("FAIL simul_write got=%0h/%0h/%0h exp=1/5/0",
                     tlb_we, tlb_w_index, tlbp_done); end
        checks++; if (s1_vpn2 !== 19'h22222) begin failures++;
            $display("FAIL simul_no_probe got=%0h exp=22222", s1_vpn2); end
        next_cycle();
        @(negedge clk);
        checks++; if ({refetch_req, tlbp_done} !== 2'b10) begin failures++;
            $display("FAIL simul_refetch got=%0b exp=10", {refetch_req, tlbp_done}); end
        next_cycle();
        ws_tlbwi_req = 1'b0; ws_tlbp_req = 1'b0;
        @(negedge clk);
        checks++; if ({tlbp_done, tlb_we, refetch_req} !== 3'b000) begin failures++;
            $display("FAIL simul_idle got=%0b exp=000", {tlbp_done, tlb_we, refetch_req}); end
    endtask

    task automatic test_reset_mid_psrch();
        next_cycle();
        cp0_entryhi_vpn2 = 19'h12345; ws_tlbp_req = 1'b1;
        next_cycle();
        s1_found = 1'b1; s1_index = 4'd11; reset = 1'b1;
        next_cycle();
        reset = 1'b0; ws_tlbp_req = 1'b0; s1_found = 1'b0; s1_index = 4'd0;
        @(negedge clk);
        checks++; if ({tlbp_done, ws_op_stall} !== 2'b00) begin failures++;
            $display("FAIL rst_psrch_done_stall got=%0b exp=00", {tlbp_done, ws_op_stall}); end
        checks++; if ({tlbp_found, tlbp_index} !== 5'd0) begin failures++;
            $display("FAIL rst_psrch_result got=%0h/%0h exp=0/0", tlbp_found, tlbp_index); end
        next_cycle();
        @(negedge clk);
        checks++; if (tlbp_done !== 1'b0) begin failures++;
            $display("FAIL rst_psrch_no_done got=%0h exp=0", tlbp_done); end
    endtask

    initial begin
        reset = 1'b1;
        ws_tlbp_req = 1'b0; ws_tlbr_req = 1'b0; ws_tlbwi_req = 1'b0; ws_reflush = 1'b0;
        cp0_entryhi_vpn2 = '0; cp0_entryhi_asid = '0; cp0_index = '0;
        es_lookup_req = 1'b0; es_vpn2 = '0; es_odd_page = 1'b0;
        s1_found = 1'b0; s1_index = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_tlbp_hit();
        test_tlbwi();
        test_tlbr();
        test_tlbp_miss();
        test_reflush_tlbr();
        test_simultaneous();
        test_reset_mid_psrch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
